// File: rtl/nco_pkg.sv
// Shared types and constants for the NCO configuration sequencer.
// Sequencer states, wave select codes and reset defaults.
package nco_pkg;

  localparam int FREQ_W = 64;
  localparam int DUTY_W = 16;
  localparam logic [15:0] DUTY_RESET = 16'h8000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_WRAP = 2'd1,
    RAMP      = 2'd2,
    DWELL     = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    WAVE_SINE   = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SAW    = 2'd3
  } wave_e;

endpackage

// File: rtl/nco_ramp_ctrl_if.sv
// Bundle between the I2C config slave, the sequencer and the NCO.
// master is the sequencer view; slave is the environment view.
interface nco_ramp_ctrl_if #(
  parameter int FREQ_W = nco_pkg::FREQ_W,
  parameter int DUTY_W = nco_pkg::DUTY_W
);
  logic              cfg_enable;
  logic [1:0]        cfg_wave;
  logic [FREQ_W-1:0] cfg_frequency;
  logic [DUTY_W-1:0] cfg_duty_cycle;
  logic              cfg_busy;
  logic              phase_wrap;
  logic              nco_enable;
  logic [1:0]        nco_wave;
  logic [FREQ_W-1:0] nco_frequency;
  logic [DUTY_W-1:0] nco_duty_cycle;
  logic              busy;
  logic              cfg_done;
  logic              wrap_timeout;

  modport master (
    input  cfg_enable, cfg_wave,
    input  cfg_frequency, cfg_duty_cycle,
    input  cfg_busy, phase_wrap,
    output nco_enable, nco_wave,
    output nco_frequency, nco_duty_cycle,
    output busy, cfg_done, wrap_timeout
  );

  modport slave (
    output cfg_enable, cfg_wave,
    output cfg_frequency, cfg_duty_cycle,
    output cfg_busy, phase_wrap,
    input  nco_enable, nco_wave,
    input  nco_frequency, nco_duty_cycle,
    input  busy, cfg_done, wrap_timeout
  );
endinterface

// File: rtl/nco_freq_stepper.sv
// Clamped step of a tuning word toward its target.
// Differences are compared before any add/subtract, so no overshoot.
module nco_freq_stepper #(
  parameter int W = 64
) (
  input  logic [W-1:0] i_cur,
  input  logic [W-1:0] i_target,
  input  logic [W-1:0] i_step,
  output logic [W-1:0] o_next
);
  logic [W-1:0] w_up;
  logic [W-1:0] w_dn;

  assign w_up = i_target - i_cur;
  assign w_dn = i_cur - i_target;

  always_comb begin
    o_next = i_cur;
    if (i_target > i_cur)
      o_next = (w_up <= i_step) ? i_target : i_cur + i_step;
    else if (i_target < i_cur)
      o_next = (w_dn <= i_step) ? i_target : i_cur - i_step;
  end
endmodule

// File: rtl/nco_ramp_ctrl.sv
// NCO configuration sequencer: commit on cfg_busy fall, wave/duty
// applied at phase wrap, tuning word ramped in clamped dwelled steps.
module nco_ramp_ctrl
  import nco_pkg::*;
#(
  parameter int              FREQ_W       = 64,
  parameter int              DUTY_W       = 16,
  parameter logic [FREQ_W-1:0] STEP       = 64'd1048576,
  parameter int unsigned     DWELL_CYCLES = 1024,
  parameter int unsigned     WRAP_TIMEOUT = 65535
) (
  input  logic          clk,
  input  logic          reset,
  nco_ramp_ctrl_if.master bus
);
  localparam logic [31:0] TMO_LD = 32'(WRAP_TIMEOUT - 1);
  localparam logic [31:0] DWL_LD = 32'(DWELL_CYCLES - 1);

  state_e            r_state, w_state;
  logic              r_busy_last;
  logic              r_en, w_en;
  logic [1:0]        r_wave, w_wave;
  logic [FREQ_W-1:0] r_freq, w_freq;
  logic [DUTY_W-1:0] r_duty, w_duty;
  logic [1:0]        r_tgt_wave, w_tgt_wave;
  logic [FREQ_W-1:0] r_tgt_freq, w_tgt_freq;
  logic [DUTY_W-1:0] r_tgt_duty, w_tgt_duty;
  logic [31:0]       r_tmo, w_tmo;
  logic [31:0]       r_dwl, w_dwl;
  logic              r_done, w_done;
  logic              r_wto, w_wto;
  logic              w_commit;
  logic [FREQ_W-1:0] w_next;

  assign w_commit = r_busy_last & ~bus.cfg_busy;

  nco_freq_stepper #(.W(FREQ_W)) u_step (
    .i_cur    (r_freq),
    .i_target (r_tgt_freq),
    .i_step   (STEP),
    .o_next   (w_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_busy_last <= 1'b1;
      r_en        <= 1'b0;
      r_wave      <= '0;
      r_freq      <= '0;
      r_duty      <= DUTY_W'(DUTY_RESET);
      r_tgt_wave  <= '0;
      r_tgt_freq  <= '0;
      r_tgt_duty  <= DUTY_W'(DUTY_RESET);
      r_tmo       <= '0;
      r_dwl       <= '0;
      r_done      <= 1'b0;
      r_wto       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_busy_last <= bus.cfg_busy;
      r_en        <= w_en;
      r_wave      <= w_wave;
      r_freq      <= w_freq;
      r_duty      <= w_duty;
      r_tgt_wave  <= w_tgt_wave;
      r_tgt_freq  <= w_tgt_freq;
      r_tgt_duty  <= w_tgt_duty;
      r_tmo       <= w_tmo;
      r_dwl       <= w_dwl;
      r_done      <= w_done;
      r_wto       <= w_wto;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_en       = r_en;
    w_wave     = r_wave;
    w_freq     = r_freq;
    w_duty     = r_duty;
    w_tgt_wave = r_tgt_wave;
    w_tgt_freq = r_tgt_freq;
    w_tgt_duty = r_tgt_duty;
    w_tmo      = r_tmo;
    w_dwl      = r_dwl;
    w_done     = 1'b0;
    w_wto      = r_wto;
    if (w_commit) begin
      w_tgt_wave = bus.cfg_wave;
      w_tgt_freq = bus.cfg_frequency;
      w_tgt_duty = bus.cfg_duty_cycle;
      w_wto      = 1'b0;
      if (!bus.cfg_enable) begin
        w_en    = 1'b0;
        w_state = IDLE;
        w_done  = 1'b1;
      end else if (!r_en) begin
        w_en    = 1'b1;
        w_wave  = bus.cfg_wave;
        w_freq  = bus.cfg_frequency;
        w_duty  = bus.cfg_duty_cycle;
        w_state = IDLE;
        w_done  = 1'b1;
      end else begin
        w_state = WAIT_WRAP;
        w_tmo   = TMO_LD;
      end
    end else begin
      unique case (r_state)
        IDLE: ;
        WAIT_WRAP: begin
          if (bus.phase_wrap || r_tmo == '0) begin
            w_wave  = r_tgt_wave;
            w_duty  = r_tgt_duty;
            w_wto   = ~bus.phase_wrap;
            w_state = RAMP;
          end else begin
            w_tmo = r_tmo - 32'd1;
          end
        end
        RAMP: begin
          if (r_freq == r_tgt_freq) begin
            w_state = IDLE;
            w_done  = 1'b1;
          end else begin
            w_freq  = w_next;
            w_dwl   = DWL_LD;
            w_state = DWELL;
          end
        end
        DWELL: begin
          if (r_dwl == '0) w_state = RAMP;
          else             w_dwl   = r_dwl - 32'd1;
        end
      endcase
    end
  end

  assign bus.nco_enable     = r_en;
  assign bus.nco_wave       = r_wave;
  assign bus.nco_frequency  = r_freq;
  assign bus.nco_duty_cycle = r_duty;
  assign bus.busy           = (r_state != IDLE);
  assign bus.cfg_done       = r_done;
  assign bus.wrap_timeout   = r_wto;
endmodule

// File: tb/tb_nco_ramp_ctrl.sv
// Directed bench for nco_ramp_ctrl.
// STEP=100, DWELL_CYCLES=4, WRAP_TIMEOUT=8.
module tb_nco_ramp_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   n_done;

  always #5 clk = ~clk;

  nco_ramp_ctrl_if #(.FREQ_W(64), .DUTY_W(16)) bus ();

  nco_ramp_ctrl #(
    .FREQ_W(64), .DUTY_W(16), .STEP(64'd100),
    .DWELL_CYCLES(4), .WRAP_TIMEOUT(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic commit();
    bus.cfg_busy = 1'b1;
    tick();
    bus.cfg_busy = 1'b0;
    tick();
  endtask

  task automatic count_done(input int n);
    n_done = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.cfg_done) n_done++;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_en"},   64'(bus.nco_enable), 64'd0);
    chk({tag, "_wave"}, 64'(bus.nco_wave), 64'd0);
    chk({tag, "_freq"}, bus.nco_frequency, 64'd0);
    chk({tag, "_duty"}, 64'(bus.nco_duty_cycle), 64'h8000);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_done"}, 64'(bus.cfg_done), 64'd0);
    chk({tag, "_wto"},  64'(bus.wrap_timeout), 64'd0);
  endtask

  initial begin
    bus.cfg_enable = 1'b0;
    bus.cfg_wave = 2'd0;
    bus.cfg_frequency = 64'd0;
    bus.cfg_duty_cycle = 16'h0;
    bus.cfg_busy = 1'b1;
    bus.phase_wrap = 1'b0;
    #2 reset = 1'b0;
    #1 chk_reset("rst0");
    @(posedge clk);
    #1 reset = 1'b1;
    tick(2);

    // direct load from disabled
    bus.cfg_enable = 1'b1;
    bus.cfg_frequency = 64'd1000;
    bus.cfg_wave = 2'd2;
    bus.cfg_duty_cycle = 16'h4000;
    commit();
    chk("ld_en",   64'(bus.nco_enable), 64'd1);
    chk("ld_freq", bus.nco_frequency, 64'd1000);
    chk("ld_wave", 64'(bus.nco_wave), 64'd2);
    chk("ld_duty", 64'(bus.nco_duty_cycle), 64'h4000);
    chk("ld_done", 64'(bus.cfg_done), 64'd1);
    chk("ld_busy", 64'(bus.busy), 64'd0);
    tick();
    chk("ld_done1", 64'(bus.cfg_done), 64'd0);

    // ramp up 1000 -> 1250 with wave change at wrap
    bus.cfg_frequency = 64'd1250;
    bus.cfg_wave = 2'd1;
    commit();
    chk("up_busy", 64'(bus.busy), 64'd1);
    chk("up_hold", bus.nco_frequency, 64'd1000);
    chk("up_wv0",  64'(bus.nco_wave), 64'd2);
    tick(2);
    bus.phase_wrap = 1'b1;
    tick();
    bus.phase_wrap = 1'b0;
    chk("up_wv1",  64'(bus.nco_wave), 64'd1);
    chk("up_f0",   bus.nco_frequency, 64'd1000);
    tick();
    chk("up_f1",   bus.nco_frequency, 64'd1100);
    tick(4);
    chk("up_f1h",  bus.nco_frequency, 64'd1100);
    tick();
    chk("up_f2",   bus.nco_frequency, 64'd1200);
    tick(5);
    chk("up_f3",   bus.nco_frequency, 64'd1250);
    count_done(8);
    chk("up_done", 64'(n_done), 64'd1);
    chk("up_idle", 64'(bus.busy), 64'd0);
    chk("up_wto",  64'(bus.wrap_timeout), 64'd0);

    // ramp down 1250 -> 1000, last step clamped
    bus.cfg_frequency = 64'd1000;
    commit();
    bus.phase_wrap = 1'b1;
    tick();
    bus.phase_wrap = 1'b0;
    tick();
    chk("dn_f1",   bus.nco_frequency, 64'd1150);
    tick(5);
    chk("dn_f2",   bus.nco_frequency, 64'd1050);
    tick(5);
    chk("dn_f3",   bus.nco_frequency, 64'd1000);
    count_done(8);
    chk("dn_done", 64'(n_done), 64'd1);
    chk("dn_fend", bus.nco_frequency, 64'd1000);

    // duty change forced by wrap timeout
    bus.cfg_duty_cycle = 16'h2000;
    commit();
    tick(7);
    chk("to_d0",   64'(bus.nco_duty_cycle), 64'h4000);
    chk("to_w0",   64'(bus.wrap_timeout), 64'd0);
    tick();
    chk("to_d1",   64'(bus.nco_duty_cycle), 64'h2000);
    chk("to_w1",   64'(bus.wrap_timeout), 64'd1);
    count_done(4);
    chk("to_done", 64'(n_done), 64'd1);
    chk("to_wst",  64'(bus.wrap_timeout), 64'd1);

    // next commit clears it; then disable mid-ramp
    bus.cfg_frequency = 64'd1250;
    commit();
    chk("to_clr",  64'(bus.wrap_timeout), 64'd0);
    bus.phase_wrap = 1'b1;
    tick();
    bus.phase_wrap = 1'b0;
    tick();
    chk("ds_f1",   bus.nco_frequency, 64'd1100);
    tick();
    bus.cfg_enable = 1'b0;
    commit();
    chk("ds_en",   64'(bus.nco_enable), 64'd0);
    chk("ds_freq", bus.nco_frequency, 64'd1100);
    chk("ds_busy", 64'(bus.busy), 64'd0);
    chk("ds_done", 64'(bus.cfg_done), 64'd1);
    tick(6);
    chk("ds_hold", bus.nco_frequency, 64'd1100);
    chk("ds_d0",   64'(bus.cfg_done), 64'd0);

    // reset pulsed mid-ramp
    bus.cfg_enable = 1'b1;
    bus.cfg_frequency = 64'd1000;
    commit();
    chk("rr_ld",   bus.nco_frequency, 64'd1000);
    bus.cfg_frequency = 64'd1250;
    commit();
    bus.phase_wrap = 1'b1;
    tick();
    bus.phase_wrap = 1'b0;
    tick(2);
    chk("rr_f1",   bus.nco_frequency, 64'd1100);
    chk("rr_busy", 64'(bus.busy), 64'd1);
    #1 reset = 1'b0;
    #1 chk_reset("rst1");
    bus.cfg_busy = 1'b1;
    tick(2);
    chk_reset("rst2");
    reset = 1'b1;
    tick(12);
    chk_reset("rst3");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/nco_ramp_ctrl.md
Name: nco_ramp_ctrl

Overview:
Configuration sequencer between the I2C configuration slave and the NCO datapath. It captures a new NCO configuration when an I2C transaction ends. Wave shape and duty-cycle changes are applied only at a phase-accumulator wrap, so no waveform glitches. The frequency tuning word is ramped toward its target in bounded steps with a dwell time between steps. Its outputs drive the NCO enable, wave, frequency and duty inputs directly.

Parameters:
FREQ_W, 64, width of frequency tuning word
DUTY_W, 16, width of duty-cycle word
STEP, 64'd1048576, maximum frequency-word change per ramp step (unsigned, >0)
DWELL_CYCLES, 1024, clk cycles held after each step (>=1)
WRAP_TIMEOUT, 65535, clk cycles to wait for phase_wrap before forcing the update (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
cfg_enable  in  1  requested NCO enable (from I2C slave)
cfg_wave  in  2  requested wave select
cfg_frequency  in  FREQ_W  requested tuning word
cfg_duty_cycle  in  DUTY_W  requested duty cycle
cfg_busy  in  1  I2C transaction-in-progress flag; its falling edge commits the config
phase_wrap  in  1  one-cycle pulse from NCO on phase-accumulator wrap
nco_enable  out  1  applied enable
nco_wave  out  2  applied wave select
nco_frequency  out  FREQ_W  applied tuning word
nco_duty_cycle  out  DUTY_W  applied duty cycle
busy  out  1  high when state != IDLE
cfg_done  out  1  one-cycle pulse when the applied config equals the committed target
wrap_timeout  out  1  sticky: last update was forced by timeout; cleared on next commit

Behaviour:
- One clock, clk. Reset is asynchronous and active-low (reset=0): all registers clear immediately.
- Reset values: nco_enable=0, nco_wave=0, nco_frequency=0, nco_duty_cycle=16'h8000, busy=0, cfg_done=0, wrap_timeout=0, state=IDLE, busy_last=1.
- Commit detection:
  - busy_last is a register of cfg_busy.
  - commit = busy_last & ~cfg_busy.
  - On commit, cfg_* are captured into target registers on that edge.
- States: IDLE, WAIT_WRAP, RAMP, DWELL.
- Commit with cfg_enable=0, from any state:
  - nco_enable<=0 on the commit edge.
  - wave, frequency and duty are held.
  - Go to IDLE; cfg_done pulses next cycle.
- Commit with cfg_enable=1 while nco_enable=0:
  - Direct load on the commit edge: enable, wave, frequency and duty all take target values.
  - Stay in or go to IDLE; cfg_done pulses next cycle; no ramp.
- Commit with cfg_enable=1 while nco_enable=1, from any state:
  - Go to WAIT_WRAP.
  - Load the timeout counter with WRAP_TIMEOUT-1.
  - Clear wrap_timeout.
  - nco_frequency is held at its current value.
- WAIT_WRAP:
  - On phase_wrap=1, apply target wave and duty, then go to RAMP.
  - Otherwise, if the counter is 0, apply wave and duty, set wrap_timeout=1, then go to RAMP.
  - Otherwise decrement the counter.
  - If phase_wrap and a new commit occur in the same cycle, the commit wins: restart WAIT_WRAP with the new targets.
- RAMP (all values unsigned):
  - If freq==target: go to IDLE and pulse cfg_done.
  - If target>freq: freq <= (target-freq <= STEP) ? target : freq+STEP.
  - If target<freq: freq <= (freq-target <= STEP) ? target : freq-STEP.
  - Compare before subtracting: no wrap-around and no overshoot.
  - After each step, load the dwell counter with DWELL_CYCLES-1 and go to DWELL.
- DWELL: decrement the counter; at 0 go to RAMP.
  - Net step period is DWELL_CYCLES+1 clk.
- A new commit mid-ramp never resets nco_frequency; the ramp continues from the current value toward the new target.
- cfg_done is exactly one cycle; busy is combinational from state.
- Reset asserted mid-ramp: outputs return to reset values immediately; any pending target is discarded.

Decomposition:
- Shared package nco_pkg:
  - state encodings;
  - wave codes;
  - FREQ_W and DUTY_W;
  - DUTY_RESET=16'h8000.
- Step/clamp arithmetic may be a sub-module, nco_freq_stepper (inputs cur, target, STEP; output next). It is kept combinational; everything else stays in nco_ramp_ctrl.

Test Plan:
Bench parameters: STEP=100, DWELL_CYCLES=4, WRAP_TIMEOUT=8.
1. Pulse reset low mid-run -> all outputs immediately return to reset values (enable=0, wave=0, freq=0, duty=16'h8000, busy=0).
2. From disabled, cfg_enable=1, freq=1000, wave=2, duty=16'h4000, then cfg_busy 1->0 -> the next cycle shows enable=1, freq=1000, wave=2, duty=16'h4000, cfg_done pulse, busy=0.
3. Enabled at 1000, commit freq=1250, wave=1, phase_wrap 3 cycles later -> wave=1 on the wrap edge, then freq 1100, 1200, 1250 with 5-cycle spacing, cfg_done once, wrap_timeout=0.
4. At 1250, commit 1000 -> freq 1150, 1050, 1000 (clamped, no undershoot); cfg_done once.
5. Enabled, commit new duty with no phase_wrap -> duty applied 8 cycles after the commit edge, wrap_timeout=1; the next commit clears it.
6. Mid-ramp (freq=1100, target 1250), commit cfg_enable=0 -> enable=0 next edge, freq held at 1100, state IDLE, cfg_done pulse.
